// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg
// Purpose: shared register-map offsets, STATUS/CTRL bit positions and a
//          small helper for the threshold interrupt condition.
// Ports:   none (package).
package uart_rx_fifo_pkg;

  // Register offsets relative to FIFO_ADDRESS.
  localparam logic [1:0] DATA_OFS   = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;  // reads STATUS, writes CTRL
  localparam logic [1:0] COUNT_OFS  = 2'd2;
  localparam logic [1:0] THRESH_OFS = 2'd3;

  // STATUS bit indices.
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_IRQ   = 3;

  // CTRL bit indices.
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 2;

  // A zero threshold disables the interrupt condition. Thresholds above
  // DEPTH are unreachable, so the condition simply never holds.
  function automatic logic f_irq_pending(input logic [7:0] count,
                                         input logic [7:0] thresh);
    return (thresh != 8'd0) && (count >= thresh);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Purpose: 8-bit peripheral I/O bus shared by the memory-mapped blocks.
// Signals: din (write data), address, w_en (write strobe), r_en (read
//          strobe), dout (registered read data from the peripheral).
// Modports: master (CPU side), slave (peripheral side).
interface uart_rx_fifo_if;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;

  modport master (output din, output address, output w_en, output r_en,
                  input dout);
  modport slave  (input din, input address, input w_en, input r_en,
                  output dout);
endinterface

// File: rtl/uart_rx_fifo_byte_fifo.sv
// uart_rx_fifo_byte_fifo
// Purpose: circular byte buffer with head/tail pointers and an occupancy
//          count. Flush has priority over push and pop; a pop frees a slot
//          so a push while full is accepted in the same cycle.
// Ports:   clk, rst (sync, active-high), i_push, i_wr_data, i_pop, i_flush,
//          o_rd_data (head byte, combinational), o_full, o_empty, o_count.
module uart_rx_fifo_byte_fifo
  #(parameter int DEPTH = 16)
  (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [7:0]                 i_wr_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [7:0]                 o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
  );

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_head];

  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_tail] <= i_wr_data;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_tail <= r_tail + {{(PW-1){1'b0}}, 1'b1};
      if (w_do_pop)  r_head <= r_head + {{(PW-1){1'b0}}, 1'b1};
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Purpose: receive-side byte FIFO behind the UART receiver with a 4-register
//          window on the I/O bus: +0 DATA (R, pops), +1 STATUS (R) / CTRL (W),
//          +2 COUNT (R), +3 THRESH (R/W).
// Ports:   clk, rst (sync, active-high), rx_byte/rx_valid (receiver strobe),
//          bus (uart_rx_fifo_if.slave, registered dout), irq (level
//          interrupt, present only when UART_FIFO_IRQ_EN is defined).
// Config:  `define UART_FIFO_IRQ_EN to add the registered irq output;
//          otherwise software polls STATUS bit3.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
  #(parameter logic [7:0] FIFO_ADDRESS = 8'h04,
    parameter int         DEPTH        = 16)
  (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_byte,
  input  logic            rx_valid,
  uart_rx_fifo_if.slave   bus
`ifdef UART_FIFO_IRQ_EN
  ,
  output logic            irq
`endif
  );

  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    w_ofs;
  logic          w_hit;
  logic          w_pop_req;
  logic          w_flush;
  logic          w_clr_ovf;
  logic          w_thresh_wr;
  logic          w_ovf_set;
  logic          w_irq_pending;
  logic [7:0]    w_rd_mux;
  logic [7:0]    w_fifo_rd;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_count8;
  logic [7:0]    r_dout;
  logic [7:0]    r_thresh;
  logic          r_ovf;

  // Offset arithmetic allows an unaligned base address.
  assign w_ofs    = bus.address - FIFO_ADDRESS;
  assign w_hit    = (w_ofs < 8'd4);
  assign w_count8 = 8'(w_count);

  assign w_irq_pending = f_irq_pending(w_count8, r_thresh);

  // Bus decode for reads, CTRL actions and THRESH writes.
  always_comb begin
    w_pop_req   = 1'b0;
    w_flush     = 1'b0;
    w_clr_ovf   = 1'b0;
    w_thresh_wr = 1'b0;
    w_rd_mux    = 8'd0;
    if (w_hit && bus.r_en) begin
      case (w_ofs[1:0])
        DATA_OFS: begin
          w_pop_req = 1'b1;
          w_rd_mux  = w_empty ? 8'd0 : w_fifo_rd;
        end
        STATUS_OFS: begin
          w_rd_mux[ST_EMPTY] = w_empty;
          w_rd_mux[ST_FULL]  = w_full;
          w_rd_mux[ST_OVF]   = r_ovf;
          w_rd_mux[ST_IRQ]   = w_irq_pending;
        end
        COUNT_OFS:  w_rd_mux = w_count8;
        THRESH_OFS: w_rd_mux = r_thresh;
        default:    w_rd_mux = 8'd0;
      endcase
    end else begin
      w_rd_mux = 8'd0;
    end
    if (w_hit && bus.w_en) begin
      case (w_ofs[1:0])
        STATUS_OFS: begin
          w_flush   = bus.din[CTRL_FLUSH];
          w_clr_ovf = bus.din[CTRL_CLR_OVF];
        end
        THRESH_OFS: w_thresh_wr = 1'b1;
        default:    w_thresh_wr = 1'b0;
      endcase
    end else begin
      w_thresh_wr = 1'b0;
    end
  end

  // A byte is lost only when full with no pop; a flush discards silently.
  assign w_ovf_set = rx_valid && w_full && !w_pop_req && !w_flush;

  uart_rx_fifo_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (rx_valid),
    .i_wr_data (rx_byte),
    .i_pop     (w_pop_req),
    .i_flush   (w_flush),
    .o_rd_data (w_fifo_rd),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Registered read data, sticky overflow (set beats clear) and threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout   <= 8'd0;
      r_thresh <= 8'd0;
      r_ovf    <= 1'b0;
    end else begin
      r_dout <= w_rd_mux;
      if (w_thresh_wr) r_thresh <= bus.din;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign bus.dout = r_dout;

`ifdef UART_FIFO_IRQ_EN
  logic r_irq;

  // Interrupt follows the pending condition one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_pending;
    end
  end

  assign irq = r_irq;
`endif

endmodule
